// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the mips32 core: program counter, instruction-memory
// addressing and the IF/ID pipeline register with stall and redirect handling.
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned IMEM_ADDR_W = 14,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [31:0]            redirect_target,
  input  logic [31:0]            imem_data,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic [31:0]            pc_if,
  output logic [31:0]            nextpc_id,
  output logic [31:0]            instruction_id,
  output logic                   valid_id,
  output logic [31:0]            fetch_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic [31:0] if_id_nextpc_q, if_id_nextpc_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] pc_plus4;

  // Wraps modulo 2^32 so the top word of the address space falls through to 0.
  assign pc_plus4 = pc_q + 32'd4;

  // Next-state selection: redirect beats stall, stall beats sequential fetch.
  always_comb begin
    pc_d           = pc_q;
    if_id_instr_d  = if_id_instr_q;
    if_id_nextpc_d = if_id_nextpc_q;
    if_id_valid_d  = if_id_valid_q;
    fetch_count_d  = fetch_count_q;
    if (redirect) begin
      // The word fetched this cycle is dropped; no delay slot.
      pc_d           = {redirect_target[31:2], 2'b00};
      if_id_instr_d  = NOP_WORD;
      if_id_nextpc_d = 32'd0;
      if_id_valid_d  = 1'b0;
    end else if (!stall) begin
      pc_d           = pc_plus4;
      if_id_instr_d  = imem_data;
      if_id_nextpc_d = pc_plus4;
      if_id_valid_d  = 1'b1;
      fetch_count_d  = fetch_count_q + 32'd1;
    end
  end

  // PC and IF/ID state with asynchronous reset into a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q           <= RESET_PC;
      if_id_instr_q  <= NOP_WORD;
      if_id_nextpc_q <= 32'd0;
      if_id_valid_q  <= 1'b0;
      fetch_count_q  <= 32'd0;
    end else begin
      pc_q           <= pc_d;
      if_id_instr_q  <= if_id_instr_d;
      if_id_nextpc_q <= if_id_nextpc_d;
      if_id_valid_q  <= if_id_valid_d;
      fetch_count_q  <= fetch_count_d;
    end
  end

  assign imem_addr      = pc_q[IMEM_ADDR_W+1:2];
  assign pc_if          = pc_q;
  assign nextpc_id      = if_id_nextpc_q;
  assign instruction_id = if_id_instr_q;
  assign valid_id       = if_id_valid_q;
  assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the driver queues the expected post-edge state
// for each cycle of stimulus, and a monitor compares it after every rising edge.
module tb_fetch_stage;

  localparam int unsigned AW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          redirect;
  logic [31:0]   redirect_target;
  logic [31:0]   imem_data;
  logic [AW-1:0] imem_addr;
  logic [31:0]   pc_if;
  logic [31:0]   nextpc_id;
  logic [31:0]   instruction_id;
  logic          valid_id;
  logic [31:0]   fetch_count;

  logic [31:0] mem [2**AW];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] np;
    logic        v;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_ADDR_W(AW),
    .NOP_WORD   (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .imem_data      (imem_data),
    .imem_addr      (imem_addr),
    .pc_if          (pc_if),
    .nextpc_id      (nextpc_id),
    .instruction_id (instruction_id),
    .valid_id       (valid_id),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " pc_if"}, pc_if, 32'h0);
    chk({tag, " instruction_id"}, instruction_id, 32'h0);
    chk({tag, " nextpc_id"}, nextpc_id, 32'h0);
    chk({tag, " valid_id"}, {31'd0, valid_id}, 32'h0);
    chk({tag, " fetch_count"}, fetch_count, 32'h0);
    chk({tag, " imem_addr"}, {18'd0, imem_addr}, 32'h0);
  endtask

  // Apply one cycle of inputs and queue the state expected after the next edge.
  task automatic step(input logic s, input logic r, input logic [31:0] tgt,
                      input logic [31:0] epc, input logic [31:0] einstr,
                      input logic [31:0] enp, input logic ev, input logic [31:0] ecnt);
    exp_t e;
    stall           = s;
    redirect        = r;
    redirect_target = tgt;
    e.pc    = epc;
    e.instr = einstr;
    e.np    = enp;
    e.v     = ev;
    e.cnt   = ecnt;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: one queued expectation per rising edge, sampled just after it.
  initial begin
    exp_t e;
    logic [31:0] eaddr;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        eaddr = {18'd0, e.pc[AW+1:2]};
        chk("pc_if", pc_if, e.pc);
        chk("instruction_id", instruction_id, e.instr);
        chk("nextpc_id", nextpc_id, e.np);
        chk("valid_id", {31'd0, valid_id}, {31'd0, e.v});
        chk("fetch_count", fetch_count, e.cnt);
        chk("imem_addr", {18'd0, imem_addr}, eaddr);
      end
    end
  end

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = 32'hDEAD_0000 | i;
    mem[0]     = 32'h1111_1111;
    mem[1]     = 32'h2222_2222;
    mem[2]     = 32'h3333_3333;
    mem[16]    = 32'hA0A0_A0A0;
    mem[17]    = 32'hA1A1_A1A1;
    mem[16383] = 32'hFFFF_0000;

    rst             = 1'b1;
    stall           = 1'b0;
    redirect        = 1'b0;
    redirect_target = 32'h0;
    #3;
    chk_reset("reset");
    @(negedge clk);
    rst = 1'b0;

    // Sequential fetch, then a two-cycle stall while pc_if=8.
    step(0, 0, 32'h0, 32'h4, 32'h1111_1111, 32'h4, 1, 32'd1);
    step(0, 0, 32'h0, 32'h8, 32'h2222_2222, 32'h8, 1, 32'd2);
    step(1, 0, 32'h0, 32'h8, 32'h2222_2222, 32'h8, 1, 32'd2);
    step(1, 0, 32'h0, 32'h8, 32'h2222_2222, 32'h8, 1, 32'd2);
    step(0, 0, 32'h0, 32'hC, 32'h3333_3333, 32'hC, 1, 32'd3);
    // Redirect to 0x40 while pc_if=12: bubble, then target instruction.
    step(0, 1, 32'h40, 32'h40, 32'h0, 32'h0, 0, 32'd3);
    step(0, 0, 32'h0, 32'h44, 32'hA0A0_A0A0, 32'h44, 1, 32'd4);
    // Stall together with redirect to an unaligned target: redirect wins.
    step(1, 1, 32'h43, 32'h40, 32'h0, 32'h0, 0, 32'd4);
    step(0, 0, 32'h0, 32'h44, 32'hA0A0_A0A0, 32'h44, 1, 32'd5);
    step(0, 0, 32'h0, 32'h48, 32'hA1A1_A1A1, 32'h48, 1, 32'd6);
    // Top of the address space, then wrap to 0.
    step(0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 32'd6);
    step(0, 0, 32'h0, 32'h0, 32'hFFFF_0000, 32'h0, 1, 32'd7);
    step(0, 0, 32'h0, 32'h4, 32'h1111_1111, 32'h4, 1, 32'd8);

    // Asynchronous reset between edges, with stall and redirect also asserted.
    stall    = 1'b1;
    redirect = 1'b1;
    redirect_target = 32'h80;
    rst = 1'b1;
    #1;
    chk_reset("midreset");
    @(negedge clk);
    chk_reset("heldreset");
    rst = 1'b0;
    step(0, 0, 32'h0, 32'h4, 32'h1111_1111, 32'h4, 1, 32'd1);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the mips32 core. It holds the program counter, drives the word address to the instruction memory, and captures the fetched instruction together with its PC+4 into the IF/ID register for the decode stage. It accepts stall requests from the hazard unit and redirect requests (taken branch or jump) from the decode stage, and it exports a fetch counter for the debug outputs of the top level.

## Interface

- RESET_PC, 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- IMEM_ADDR_W, 14: width of the instruction-memory word address.
- NOP_WORD, 32'h0000_0000: instruction injected into IF/ID on flush or reset (sll $0,$0,0).

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold the PC and IF/ID contents.
- redirect  in  1  taken branch or jump resolved in ID; flush IF/ID and load the target.
- redirect_target  in  32  new PC; bits [1:0] are ignored and forced to 0.
- imem_data  in  32  instruction word at imem_addr; combinational read, valid in the same cycle.
- imem_addr  out  IMEM_ADDR_W  pc[IMEM_ADDR_W+1:2].
- pc_if  out  32  current fetch PC.
- nextpc_id  out  32  registered PC+4 of the instruction in IF/ID.
- instruction_id  out  32  registered instruction in IF/ID.
- valid_id  out  1  IF/ID holds a real fetched instruction (0 means bubble).
- fetch_count  out  32  number of instructions loaded into IF/ID since reset.

## Operation

- Registers: pc, if_id_instr, if_id_nextpc, if_id_valid, fetch_count.
- pc_plus4 = pc + 4, computed modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- The following priority applies at each rising edge when rst is low:
  1. redirect=1: pc <= {redirect_target[31:2],2'b00}; if_id_instr <= NOP_WORD; if_id_nextpc <= 0; if_id_valid <= 0; fetch_count holds. This applies even when stall=1, so redirect always wins.
  2. Else stall=1: all registers hold.
  3. Else: pc <= pc_plus4; if_id_instr <= imem_data; if_id_nextpc <= pc_plus4; if_id_valid <= 1; fetch_count <= fetch_count + 1, wrapping at 2^32.
- The instruction fetched in the cycle that redirect is asserted is discarded. The block provides no delay slot.
- The outputs pc_if, nextpc_id, instruction_id and valid_id are direct register outputs. imem_addr is a combinational slice of pc.
- The block performs no decoding. Alignment is enforced only on redirect targets.

## Timing

- rst high: immediately and asynchronously pc=RESET_PC, instruction_id=NOP_WORD, nextpc_id=0, valid_id=0, fetch_count=0, imem_addr=RESET_PC[IMEM_ADDR_W+1:2].
- First edge after rst falls: instruction_id = mem[RESET_PC>>2], nextpc_id=RESET_PC+4, valid_id=1.
- Latency: the instruction at PC p appears on instruction_id one cycle after pc_if=p, provided there is no stall and no redirect.
- Throughput: one instruction per cycle.
- Redirect penalty: a redirect asserted in cycle n gives a bubble (valid_id=0) in cycle n+1. Target T is on pc_if in cycle n+1, and its instruction reaches instruction_id in cycle n+2.
- Stall held for k cycles: pc_if and IF/ID are frozen for exactly k edges. The stream resumes without skipping or duplicating an instruction.
- Reset asserted mid-stream: the block returns to the reset state in the same cycle, regardless of stall or redirect.

## Test plan

- Reset and sequential fetch: the memory holds words 0x11111111, 0x22222222, 0x33333333 at 0, 4, 8. After release of rst, instruction_id/nextpc_id over three cycles are 0x11111111/4, 0x22222222/8, 0x33333333/12, and fetch_count is 3.
- Stall: assert stall for 2 cycles while pc_if=8. pc_if stays 8 and instruction_id stays 0x22222222 for both cycles. On release, 0x33333333 follows with nextpc_id=12.
- Redirect: assert redirect with target 0x40 while pc_if=12. The next cycle shows valid_id=0, instruction_id=NOP_WORD and pc_if=0x40. The cycle after that shows instruction_id=mem[0x40] and nextpc_id=0x44. fetch_count is unchanged during the bubble.
- Simultaneous stall and redirect with target 0x43: pc_if becomes 0x40, valid_id=0, and the stall is ignored.
- Wrap-around: redirect to 0xFFFFFFFC. The next edge gives pc_if=0, nextpc_id=0, and imem_addr wraps to 0.
- Reset mid-operation: assert rst between clock edges while valid_id=1. All outputs go to their reset values before the next edge.
